// File: rtl/shot_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shot_scheduler: APB/button shot arbiter with ammo budget and cooldown.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module shot_scheduler #(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [2:0]  BTN_CMD     = 3'b100,
  parameter int          TX_START_TO = 1024,
  parameter logic [23:0] COOL_RST    = 24'd5000000
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        fire_btn,
  input  logic        tx_busy,
  output logic        fire_valid,
  output logic [2:0]  fire_cmd,
  output logic        ammo_empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_COOL       = 3'd4
  } state_t;

  state_t r_state, w_next;

  logic [2:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_ammo;
  logic [23:0]      r_cooldown;
  logic [23:0]      r_timer;
  logic             r_ovf, r_tx_err, r_btn_pending, r_btn_d;
  logic [2:0]       r_sync;

  logic w_wr, w_sel_shot, w_sel_ammo, w_sel_cool, w_sel_stat;
  logic w_full, w_push_req, w_push, w_pop, w_btn_rise;
  logic w_grant_btn, w_grant_sw, w_set_txerr, w_timer_clr;
  logic w_unused;

  assign w_wr       = PSEL & PENABLE & PWRITE;
  assign w_sel_shot = (PADDR[3:2] == 2'd0);
  assign w_sel_ammo = (PADDR[3:2] == 2'd1);
  assign w_sel_cool = (PADDR[3:2] == 2'd2);
  assign w_sel_stat = (PADDR[3:2] == 2'd3);
  assign w_unused   = ^{PADDR[7:4], PADDR[1:0], PWDATA[31:24]};

  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push_req = w_wr & w_sel_shot;
  // A concurrent pop frees a slot, so a push into a full FIFO is still accepted.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_pop      = w_grant_sw;
  assign w_btn_rise = r_sync[2] & ~r_btn_d;

  assign PREADY     = 1'b1;
  assign PSLVERR    = 1'b0;
  assign fire_valid = (r_state == S_ISSUE);
  assign ammo_empty = (r_ammo == 8'd0);

  always_comb begin
    PRDATA = '0;
    if (PSEL & ~PWRITE) begin
      case (PADDR[3:2])
        2'd1: PRDATA[7:0]  = r_ammo;
        2'd2: PRDATA[23:0] = r_cooldown;
        2'd3: begin
          PRDATA[2 +: CNT_W] = r_count;
          PRDATA[8]          = r_ovf;
          PRDATA[9]          = r_tx_err;
        end
        default: PRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_grant_btn = 1'b0;
    w_grant_sw  = 1'b0;
    w_set_txerr = 1'b0;
    w_timer_clr = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_ammo != 8'd0) begin
          if (r_btn_pending) begin
            w_grant_btn = 1'b1;
            w_next      = S_ISSUE;
          end else if (r_count != '0) begin
            w_grant_sw = 1'b1;
            w_next     = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        w_timer_clr = 1'b1;
        w_next      = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (tx_busy) begin
          w_next = S_WAIT_DONE;
        end else if (r_timer == 24'(TX_START_TO - 1)) begin
          w_set_txerr = 1'b1;
          w_timer_clr = 1'b1;
          w_next      = S_COOL;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          w_timer_clr = 1'b1;
          w_next      = S_COOL;
        end
      end
      S_COOL: begin
        if (r_timer >= r_cooldown) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_sync        <= '0;
      r_btn_d       <= 1'b0;
      r_btn_pending <= 1'b0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_ammo        <= '0;
      r_cooldown    <= COOL_RST;
      r_timer       <= '0;
      r_ovf         <= 1'b0;
      r_tx_err      <= 1'b0;
      fire_cmd      <= '0;
    end else begin
      r_sync  <= {r_sync[1:0], fire_btn};
      r_btn_d <= r_sync[2];

      if (w_grant_btn)     r_btn_pending <= 1'b0;
      else if (w_btn_rise) r_btn_pending <= 1'b1;

      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      if (w_grant_btn)     fire_cmd <= BTN_CMD;
      else if (w_grant_sw) fire_cmd <= r_mem[r_rptr];

      // Software write beats the issue-time decrement.
      if (w_wr & w_sel_ammo)
        r_ammo <= PWDATA[7:0];
      else if ((r_state == S_ISSUE) && (r_ammo != 8'd0))
        r_ammo <= r_ammo - 8'd1;

      if (w_wr & w_sel_cool) r_cooldown <= PWDATA[23:0];

      if (w_timer_clr)
        r_timer <= '0;
      else if ((r_state == S_WAIT_START) || (r_state == S_COOL))
        r_timer <= r_timer + 24'd1;

      if (w_push_req & ~w_push)             r_ovf <= 1'b1;
      else if (w_wr & w_sel_stat & PWDATA[8]) r_ovf <= 1'b0;

      if (w_set_txerr)                      r_tx_err <= 1'b1;
      else if (w_wr & w_sel_stat & PWDATA[9]) r_tx_err <= 1'b0;
    end
  end

  always_ff @(posedge PCLK) begin
    if (w_push) r_mem[r_wptr] <= PWDATA[2:0];
  end

endmodule
`default_nettype wire

// File: tb/tb_shot_scheduler.sv
`default_nettype none
// Scoreboard bench for shot_scheduler: expected fire_cmd values are queued at
// stimulus time and popped by a monitor on every fire_valid strobe.
module tb_shot_scheduler;

  logic        PCLK = 1'b0;
  logic        PRESETN = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [7:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        fire_btn = 1'b0;
  logic        tx_busy = 1'b0;
  logic        fire_valid;
  logic [2:0]  fire_cmd;
  logic        ammo_empty;

  shot_scheduler dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .fire_btn(fire_btn),
    .tx_busy(tx_busy), .fire_valid(fire_valid), .fire_cmd(fire_cmd),
    .ammo_empty(ammo_empty)
  );

  always #5 PCLK = ~PCLK;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  logic [2:0] exp_q[$];
  int strobe_cyc[64];
  int strobe_n = 0;
  int fall_cyc[64];
  int fall_n = 0;
  bit tx_en = 1'b1;
  int busy_len = 20;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // Transmitter model: busy rises 2 cycles after a strobe, lasts busy_len cycles.
  initial begin
    int dly, bcnt;
    dly = 0; bcnt = 0;
    forever begin
      @(negedge PCLK);
      if (!PRESETN) begin
        dly = 0; bcnt = 0; tx_busy = 1'b0;
      end else if (fire_valid && tx_en) begin
        dly = 2;
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin tx_busy = 1'b1; bcnt = busy_len; end
      end else if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) begin
          tx_busy = 1'b0;
          fall_cyc[fall_n] = cyc;
          fall_n++;
        end
      end
    end
  end

  initial begin
    logic [2:0] e;
    forever begin
      @(negedge PCLK);
      if (PRESETN && fire_valid) begin
        strobe_cyc[strobe_n] = cyc;
        strobe_n++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_strobe: fire_cmd=%b with no shot expected", fire_cmd);
        end else begin
          e = exp_q.pop_front();
          if (fire_cmd !== e) begin
            n_err++;
            $display("FAIL fire_cmd: got %b expected %b", fire_cmd, e);
          end
        end
      end
    end
  end

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
    #1 d = PRDATA;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wait_strobes(input string nm, input int n, input int budget);
    int k;
    k = 0;
    while (strobe_n < n && k < budget) begin
      @(negedge PCLK); #2;
      k++;
    end
    check(nm, strobe_n, n);
  endtask

  task automatic press(input int hi);
    @(negedge PCLK);
    fire_btn = 1'b1;
    repeat (hi) @(negedge PCLK);
    fire_btn = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int base, c0;

    repeat (3) @(negedge PCLK);
    #1;
    check("rst_fire_valid", fire_valid, 0);
    check("rst_fire_cmd", fire_cmd, 0);
    check("rst_ammo_empty", ammo_empty, 1);
    PRESETN = 1'b1;
    apb_read(8'h04, d); check("rst_ammo", d, 0);
    apb_read(8'h08, d); check("rst_cooldown", d, 32'd5000000);
    apb_read(8'h0C, d); check("rst_status", d, 0);

    // 1: two software shots with cooldown spacing
    base = strobe_n;
    apb_write(8'h08, 32'd10);
    apb_write(8'h04, 32'd2);
    exp_q.push_back(3'b001); apb_write(8'h00, 32'b001);
    exp_q.push_back(3'b101); apb_write(8'h00, 32'b101);
    wait_strobes("t1_strobes", base + 2, 300);
    repeat (60) @(negedge PCLK);
    check("t1_gap_ge_cooldown", (strobe_cyc[base + 1] - fall_cyc[fall_n - 2]) >= 10, 1);
    apb_read(8'h04, d); check("t1_ammo", d, 0);
    check("t1_ammo_empty", ammo_empty, 1);

    // 2: overflow while a shot is in flight
    base = strobe_n;
    apb_write(8'h04, 32'd5);
    exp_q.push_back(3'b010); apb_write(8'h00, 32'b010);
    exp_q.push_back(3'b011); apb_write(8'h00, 32'b011);
    exp_q.push_back(3'b100); apb_write(8'h00, 32'b100);
    exp_q.push_back(3'b101); apb_write(8'h00, 32'b101);
    exp_q.push_back(3'b110); apb_write(8'h00, 32'b110);
    apb_write(8'h00, 32'b111);
    apb_read(8'h0C, d); check("t2_status_full_ovf", d, 32'h110);
    apb_write(8'h0C, 32'h100);
    apb_read(8'h0C, d); check("t2_ovf_cleared", d[8], 0);
    wait_strobes("t2_strobes", base + 5, 500);
    repeat (150) @(negedge PCLK);
    check("t2_no_extra", strobe_n, base + 5);
    apb_read(8'h04, d); check("t2_ammo", d, 0);

    // 3: button priority and press coalescing
    base = strobe_n;
    apb_write(8'h00, 32'b000);
    press(2);
    repeat (10) @(negedge PCLK);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b000);
    apb_write(8'h04, 32'd4);
    wait_strobes("t3_first_two", base + 2, 200);
    exp_q.push_back(3'b100);
    press(3);
    repeat (4) @(negedge PCLK);
    press(3);
    wait_strobes("t3_btn_shot", base + 3, 200);
    repeat (150) @(negedge PCLK);
    check("t3_no_extra", strobe_n, base + 3);
    apb_read(8'h04, d); check("t3_ammo", d, 1);

    // 4: transmitter never starts
    tx_en = 1'b0;
    base = strobe_n;
    apb_write(8'h04, 32'd1);
    exp_q.push_back(3'b011); apb_write(8'h00, 32'b011);
    wait_strobes("t4_strobe", base + 1, 20);
    repeat (500) @(negedge PCLK);
    apb_read(8'h0C, d); check("t4_txerr_early", d[9], 0);
    repeat (600) @(negedge PCLK);
    apb_read(8'h0C, d); check("t4_txerr_set", d[9], 1);
    apb_read(8'h04, d); check("t4_ammo", d, 0);
    apb_write(8'h0C, 32'h200);
    apb_read(8'h0C, d); check("t4_txerr_cleared", d[9], 0);
    tx_en = 1'b1;

    // 5: no ammo blocks a queued shot; refill launches after one cycle
    base = strobe_n;
    exp_q.push_back(3'b110); apb_write(8'h00, 32'b110);
    repeat (1000) @(negedge PCLK);
    check("t5_blocked", strobe_n, base);
    apb_write(8'h04, 32'd1);
    c0 = cyc;
    wait_strobes("t5_strobe", base + 1, 20);
    check("t5_latency", strobe_cyc[base] - c0, 1);
    repeat (60) @(negedge PCLK);

    // 6: reset during WAIT_DONE
    busy_len = 40;
    base = strobe_n;
    apb_write(8'h04, 32'd2);
    exp_q.push_back(3'b101); apb_write(8'h00, 32'b101);
    apb_write(8'h00, 32'b111);
    wait_strobes("t6_strobe", base + 1, 20);
    repeat (12) @(negedge PCLK);
    #2 PRESETN = 1'b0;
    #1;
    check("t6_fire_valid", fire_valid, 0);
    check("t6_fire_cmd", fire_cmd, 0);
    repeat (3) @(negedge PCLK);
    PRESETN = 1'b1;
    apb_read(8'h04, d); check("t6_ammo", d, 0);
    apb_read(8'h08, d); check("t6_cooldown", d, 32'd5000000);
    apb_read(8'h0C, d); check("t6_status", d, 0);
    check("t6_ammo_empty", ammo_empty, 1);
    repeat (100) @(negedge PCLK);
    check("t6_no_strobe", strobe_n, base + 1);
    check("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
